// File: rtl/nand_reduce_pipe.sv
// Pipelined N-input logic gate: one balanced reduction-tree level per register stage, with
// valid/ready flow control and a saturating counter of output value changes.
module nand_reduce_pipe #(
    parameter int N_IN  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in1,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out1,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr,
    output logic [CNT_W-1:0] toggle_cnt
);
    localparam int LAT = $clog2(N_IN);

    // Number of live elements entering tree level k.
    function automatic int lvl_w(input int k);
        int w;
        w = N_IN;
        for (int j = 0; j < k; j++) w = (w + 1) / 2;
        return w;
    endfunction

    function automatic logic base_op(input logic a, input logic b, input logic [2:0] m);
        case (m)
            3'd2, 3'd3: return a | b;
            3'd4, 3'd5: return a ^ b;
            default:    return a & b;
        endcase
    endfunction

    // NAND, NOR, XNOR and the reserved codes (treated as NAND) invert the base result.
    function automatic logic inv_op(input logic [2:0] m);
        return (m == 3'd0) || (m == 3'd2) || (m >= 3'd5);
    endfunction

    function automatic logic [N_IN-1:0] reduce_level(input logic [N_IN-1:0] v, input int w,
                                                     input logic [2:0] m);
        logic [N_IN-1:0] r;
        r = '0;
        for (int i = 0; i < N_IN / 2; i++) begin
            if (2 * i + 1 < w)  r[i] = base_op(v[2*i], v[2*i+1], m);
            else if (2 * i < w) r[i] = v[2*i];
        end
        // Odd top element of the first level has no partner inside the pair loop.
        if ((N_IN % 2 == 1) && (w == N_IN)) r[N_IN/2] = v[N_IN-1];
        return r;
    endfunction

    logic [N_IN-1:0]  r_data    [LAT];
    logic [2:0]       r_op      [LAT];
    logic             r_vld     [LAT];
    logic [N_IN-1:0]  w_src     [LAT];
    logic [2:0]       w_src_op  [LAT];
    logic             w_src_vld [LAT];
    logic [N_IN-1:0]  w_nxt     [LAT];
    logic             w_advance;
    logic             w_xfer;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             w_unused_bits;

    always_comb begin
        w_src[0]     = in1;
        w_src_op[0]  = op;
        w_src_vld[0] = in_valid;
        for (int k = 1; k < LAT; k++) begin
            w_src[k]     = r_data[k-1];
            w_src_op[k]  = r_op[k-1];
            w_src_vld[k] = r_vld[k-1];
        end
        for (int k = 0; k < LAT; k++) begin
            w_nxt[k] = reduce_level(w_src[k], lvl_w(k), w_src_op[k]);
        end
    end

    assign w_advance  = out_ready | ~r_vld[LAT-1];
    assign in_ready   = w_advance;
    assign out_valid  = r_vld[LAT-1];
    assign out1       = r_data[LAT-1][0];
    assign w_xfer     = r_vld[LAT-1] & out_ready;
    assign toggle_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
                r_op[k]   <= '0;
                r_vld[k]  <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < LAT - 1; k++) begin
                r_data[k] <= w_nxt[k];
                r_op[k]   <= w_src_op[k];
                r_vld[k]  <= w_src_vld[k];
            end
            r_vld[LAT-1] <= w_src_vld[LAT-1];
            r_op[LAT-1]  <= w_src_op[LAT-1];
            // Output data only moves for real items so bubbles leave out1 untouched.
            if (w_src_vld[LAT-1]) begin
                r_data[LAT-1] <= {w_nxt[LAT-1][N_IN-1:1],
                                  w_nxt[LAT-1][0] ^ inv_op(w_src_op[LAT-1])};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_xfer) r_last <= out1;
            if (clr) begin
                r_cnt <= '0;
            end else if (w_xfer && (out1 != r_last) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_unused_bits = ^{r_op[LAT-1], r_data[LAT-1][N_IN-1:1]};

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Directed bench: three instances (N_IN=8, odd N_IN=5 with 2-bit counter, N_IN=2 with LAT=1).
module tb_nand_reduce_pipe;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [7:0]  a_in1;
    logic [2:0]  a_op;
    logic        a_in_valid, a_in_ready, a_out1, a_out_valid, a_out_ready, a_clr;
    logic [15:0] a_cnt;
    logic [4:0]  b_in1;
    logic [2:0]  b_op;
    logic        b_in_valid, b_in_ready, b_out1, b_out_valid, b_out_ready, b_clr;
    logic [1:0]  b_cnt;
    logic [1:0]  c_in1;
    logic [2:0]  c_op;
    logic        c_in_valid, c_in_ready, c_out1, c_out_valid, c_out_ready, c_clr;
    logic [15:0] c_cnt;

    nand_reduce_pipe #(.N_IN(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .in1(a_in1), .op(a_op), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out1(a_out1), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .clr(a_clr), .toggle_cnt(a_cnt)
    );
    nand_reduce_pipe #(.N_IN(5), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in1(b_in1), .op(b_op), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out1(b_out1), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .clr(b_clr), .toggle_cnt(b_cnt)
    );
    nand_reduce_pipe #(.N_IN(2), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .in1(c_in1), .op(c_op), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out1(c_out1), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .clr(c_clr), .toggle_cnt(c_cnt)
    );

    typedef struct {
        logic [7:0] din;
        logic [2:0] op;
        logic       exp;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    logic got_a[$];
    int   cyc_a[$];
    logic exp_a[$];
    logic got_b[$];
    logic exp_b[$];
    int   exp_cnt_a = 0;
    logic exp_last_a = 1'b0;

    // Output transfers are taken at the next rising edge; record them half a cycle early.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            got_a.push_back(a_out1);
            cyc_a.push_back(cyc);
        end
        if (!rst && b_out_valid && b_out_ready) got_b.push_back(b_out1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp_a(input logic r);
        exp_a.push_back(r);
        if (r != exp_last_a) exp_cnt_a++;
        exp_last_a = r;
    endfunction

    task automatic send_a(input vec_t v);
        a_in1 = v.din;
        a_op = v.op;
        a_in_valid = 1'b1;
        push_exp_a(v.exp);
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input vec_t v);
        b_in1 = v.din[4:0];
        b_op = v.op;
        b_in_valid = 1'b1;
        exp_b.push_back(v.exp);
        step();
        b_in_valid = 1'b0;
    endtask

    task automatic cmp_a(input string name);
        check({name, "_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) check(name, got_a[i], exp_a[i]);
        got_a.delete();
        exp_a.delete();
        cyc_a.delete();
    endtask

    task automatic cmp_b(input string name);
        check({name, "_count"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) check(name, got_b[i], exp_b[i]);
        got_b.delete();
        exp_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv_a[14];
        vec_t st_a[6];
        vec_t tv_b[5];
        int   n;
        int   idx;
        logic seen;

        tv_a[0]  = '{8'hFF, 3'd0, 1'b0};
        tv_a[1]  = '{8'hFE, 3'd0, 1'b1};
        tv_a[2]  = '{8'hFF, 3'd1, 1'b1};
        tv_a[3]  = '{8'h7F, 3'd1, 1'b0};
        tv_a[4]  = '{8'h00, 3'd2, 1'b1};
        tv_a[5]  = '{8'h10, 3'd2, 1'b0};
        tv_a[6]  = '{8'h00, 3'd3, 1'b0};
        tv_a[7]  = '{8'h80, 3'd3, 1'b1};
        tv_a[8]  = '{8'h07, 3'd4, 1'b1};
        tv_a[9]  = '{8'h07, 3'd5, 1'b0};
        tv_a[10] = '{8'h03, 3'd4, 1'b0};
        tv_a[11] = '{8'hFF, 3'd6, 1'b0};
        tv_a[12] = '{8'h00, 3'd7, 1'b1};
        tv_a[13] = '{8'hA5, 3'd5, 1'b1};
        st_a[0] = '{8'h01, 3'd4, 1'b1};
        st_a[1] = '{8'h03, 3'd4, 1'b0};
        st_a[2] = '{8'hFF, 3'd0, 1'b0};
        st_a[3] = '{8'h00, 3'd2, 1'b1};
        st_a[4] = '{8'h80, 3'd3, 1'b1};
        st_a[5] = '{8'h7F, 3'd1, 1'b0};
        tv_b[0] = '{8'h00, 3'd2, 1'b1};
        tv_b[1] = '{8'h10, 3'd2, 1'b0};
        tv_b[2] = '{8'h00, 3'd2, 1'b1};
        tv_b[3] = '{8'h10, 3'd2, 1'b0};
        tv_b[4] = '{8'h00, 3'd2, 1'b1};

        {a_in1, a_op, a_in_valid, a_out_ready, a_clr} = '0;
        {b_in1, b_op, b_in_valid, b_out_ready, b_clr} = '0;
        {c_in1, c_op, c_in_valid, c_out_ready, c_clr} = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out1", a_out1, 0);
        check("rst_toggle_cnt", a_cnt, 0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;

        // XOR then XNOR of 0x07, back to back: 1 then 0, each a change of value.
        send_a('{8'h07, 3'd4, 1'b1});
        send_a('{8'h07, 3'd5, 1'b0});
        repeat (6) step();
        if (cyc_a.size() >= 2) check("xor_xnor_consecutive", cyc_a[1] - cyc_a[0], 1);
        else check("xor_xnor_consecutive", cyc_a.size(), 2);
        cmp_a("xor_xnor");
        check("xor_xnor_toggle_cnt", a_cnt, exp_cnt_a);

        // Latency: input transfer edge counts as cycle 1.
        a_in1 = 8'hFF;
        a_op = 3'd0;
        a_in_valid = 1'b1;
        push_exp_a(1'b0);
        step();
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 10) begin
            step();
            n++;
        end
        check("latency_n8", n, 3);
        check("latency_n8_out1", a_out1, 0);
        repeat (4) step();
        cmp_a("latency");

        foreach (tv_a[i]) send_a(tv_a[i]);
        repeat (6) step();
        cmp_a("table_n8");
        check("table_n8_toggle_cnt", a_cnt, exp_cnt_a);
        check("bubble_out_valid", a_out_valid, 0);
        check("bubble_out1_hold", a_out1, 1);

        // Six-item stream with out_ready low for cycles 3..6.
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            a_out_ready = !(c >= 3 && c <= 6);
            if (idx < 6) begin
                a_in1 = st_a[idx].din;
                a_op = st_a[idx].op;
                a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 6) check("stall_in_ready", a_in_ready, 0);
            if (a_in_valid && a_in_ready) begin
                push_exp_a(st_a[idx].exp);
                idx++;
            end
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        cmp_a("stall_stream");
        check("stall_toggle_cnt", a_cnt, exp_cnt_a);

        // Reset with three items in flight and the output stalled.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in1 = 8'h00;
            a_op = 3'd0;
            a_in_valid = 1'b1;
            step();
        end
        a_in_valid = 1'b0;
        check("inflight_out_valid", a_out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_inflight_out_valid", a_out_valid, 0);
        a_out_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (a_out_valid) seen = 1'b1;
        end
        check("rst_inflight_no_output", seen, 0);
        check("rst_inflight_got", got_a.size(), 0);
        check("rst_inflight_toggle_cnt", a_cnt, 0);
        got_a.delete();
        cyc_a.delete();

        // Odd tree NOR with five alternating results saturates the 2-bit counter.
        foreach (tv_b[i]) send_b(tv_b[i]);
        repeat (6) step();
        cmp_b("odd_nor");
        check("sat_toggle_cnt", b_cnt, 3);

        // clr lands on a toggling transfer; the next opposite result proves last_out moved.
        send_b('{8'h10, 3'd2, 1'b0});
        n = 1;
        while (!b_out_valid && n < 10) begin
            step();
            n++;
        end
        check("clr_wait_valid", b_out_valid, 1);
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        check("clr_wins_toggle_cnt", b_cnt, 0);
        send_b('{8'h00, 3'd2, 1'b1});
        repeat (5) step();
        check("clr_last_out_updated", b_cnt, 1);
        cmp_b("clr_seq");

        // Two-input instance: single-cycle latency.
        c_in1 = 2'b11;
        c_op = 3'd0;
        c_in_valid = 1'b1;
        step();
        check("n2_latency_valid", c_out_valid, 1);
        check("n2_nand_out1", c_out1, 0);
        c_in1 = 2'b01;
        c_op = 3'd4;
        step();
        c_in_valid = 1'b0;
        check("n2_xor_valid", c_out_valid, 1);
        check("n2_xor_out1", c_out1, 1);
        step();
        check("n2_bubble_valid", c_out_valid, 0);
        check("n2_toggle_cnt", c_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
